issue_scheduler: RTL and testbench
==================================

// Module: issue_scheduler
// PURPOSE
//  In-order-age reservation station between ID-stage operand generation and one execution unit.
//  - Accepts decoded ops with two operands. Each operand is a value or a rename reference (tag).
//  - Snoops the result broadcast bus (CDB) to capture pending operands.
//  - Issues the oldest fully-ready op to the FU over a valid/ready handshake.
// PARAMETERS
//  ENTRY_NUM     4   number of station entries (>=2)
//  TAG_WIDTH     6   rename tag width; when is_ref=1 the tag is data[TAG_WIDTH-1:0]
//  PAYLOAD_WIDTH 16  opaque op payload (op/funct/dest), passed through unchanged
// PORTS
//  clk              in   1             clock
//  rst              in   1             reset, synchronous, active-low
//  flush            in   1             discard all entries (branch mispredict/exception)
//  disp_valid       in   1             dispatch request
//  disp_ready       out  1             station can accept this cycle
//  disp_payload     in   PAYLOAD_WIDTH op payload
//  disp_is_ref_1/2  in   1             operand 1/2 is a tag, not a value
//  disp_data_1/2    in   32            operand 1/2 value or tag
//  cdb_valid        in   1             result broadcast valid
//  cdb_tag          in   TAG_WIDTH     broadcast tag
//  cdb_data         in   32            broadcast value
//  issue_valid      out  1             selected entry ready to issue
//  issue_ready      in   1             FU accepts
//  issue_payload    out  PAYLOAD_WIDTH payload of selected entry
//  issue_data_1/2   out  32            resolved operand values
//  entry_count      out  clog2(ENTRY_NUM+1)  occupied entries
// BEHAVIOUR
//  Reset (rst=0 at clk edge):
//  - All entries invalid; entry_count=0; disp_ready=1 on the next cycle.
//  - issue_valid=0; issue_* data/payload=0.
//  Storage: compacting queue. Index 0 is the oldest entry; valid entries are contiguous from 0.
//  disp_ready = (entry_count != ENTRY_NUM):
//  - Registered state only; no same-cycle issue credit.
//  - When full, a disp_valid is held off; no entry is written.
//  Dispatch (disp_valid & disp_ready): the entry is written at index entry_count, shifted down
//  by one if an issue fires in the same cycle.
//  Dispatch-time snoop (mandatory): a disp operand with is_ref=1 and tag==cdb_tag while
//  cdb_valid=1 is stored as a value (cdb_data, is_ref=0).
//  Wakeup: every valid entry operand with is_ref=1 and matching cdb_tag under cdb_valid takes
//  cdb_data and clears is_ref at the edge. All matching entries/operands update simultaneously.
//  Ready = valid & !is_ref_1 & !is_ref_2.
//  Select: lowest-index ready entry. issue_* are combinational from entry state. An entry may
//  issue out of order ahead of older non-ready entries.
//  Issue (issue_valid & issue_ready): at the edge the entry is removed; entries above it shift
//  down by one, keeping age order.
//  issue_valid=1 with issue_ready=0: the output holds stable unless an older entry becomes ready
//  (allowed to change, FU must sample only on handshake).
//  Latency:
//  - Dispatch of an all-value op -> issue_valid the next cycle.
//  - CDB wakeup at cycle T -> issue_valid at T+1 (default).
//  Simultaneous dispatch+issue+wakeup are all legal in one cycle; entry_count changes by
//  (+disp -issue).
//  flush=1: all entries are invalidated at the edge. Flush overrides dispatch, issue bookkeeping
//  and wakeup. disp_ready is unaffected that cycle. An issue handshake in the flush cycle still
//  completes at the FU.
//  Reset mid-operation behaves as flush plus output clear.
// CONFIGURATION
//  ISSUE_SCHED_FAST_WAKEUP_EN:
//  - Defined: an entry whose only remaining ref operands match the current CDB is treated as
//    ready this cycle. issue_data_x is muxed from cdb_data (wakeup->issue latency 0). The entry
//    still captures the value if not issued.
//  - Undefined: wakeup->issue latency is 1 cycle; issue path has no CDB dependence.
// STRUCTURE
//  Shared header sched.v (`define style like bus.v):
//  - SCHED_TAG_BUS, SCHED_PAYLOAD_BUS, SCHED_ENTRY_NUM defaults.
//  - Tag-extract macro for data[TAG_WIDTH-1:0].
//  Sub-module sched_entry:
//  - One slot: valid, payload, 2x{is_ref,data}.
//  - Wakeup compare; load-from-dispatch / load-from-upper-neighbour (shift) / clear.
//  - Exposes ready.
//  Top: generate ENTRY_NUM sched_entry instances, priority select, count register.
// TESTING
//  1. Dispatch values (5,7) into empty station -> next cycle issue_valid=1, data 5/7;
//     issue_ready=1 -> entry_count 1->0.
//  2. Fill 4 entries with ref tag 3, issue_ready=1 -> disp_ready=0, 5th dispatch dropped;
//     CDB tag 3 data 0xAB -> all 4 wake, issue in index order 0..3 over 4 cycles, each operand 0xAB.
//  3. Dispatch op1 ref tag 9 in same cycle as CDB tag 9 data 0x11 -> stored as value,
//     issued next cycle with data_1=0x11.
//  4. Entry0 waits on tag 2, entry1 ready -> entry1 issues first; then CDB tag 2 -> entry0 issues
//     (T+1 without FAST_WAKEUP_EN, T with it).
//  5. Three entries valid, flush=1 together with disp_valid=1 -> entry_count=0, issue_valid=0
//     next cycle; rst=0 mid-stream -> same plus zeroed outputs.

Source files
------------

// File: rtl/issue_scheduler_pkg.sv
// issue_scheduler_pkg: shared types and helpers for the issue scheduler slice.
//   SCHED_ENTRY_NUM / SCHED_TAG_WIDTH / SCHED_PAYLOAD_WIDTH : default sizes
//   operand_t       : one operand slot {is_ref, data}; when is_ref the tag is data[TAG_WIDTH-1:0]
//   entry_op_e      : per-slot next-state selection driven by the top
//   tag_mask()      : mask selecting the tag bits out of a 32-bit operand word
//   wake_operand()  : CDB capture of a single operand
package issue_scheduler_pkg;

  localparam int unsigned SCHED_ENTRY_NUM     = 4;
  localparam int unsigned SCHED_TAG_WIDTH     = 6;
  localparam int unsigned SCHED_PAYLOAD_WIDTH = 16;
  localparam int unsigned DATA_W              = 32;

  typedef struct packed {
    logic              is_ref;
    logic [DATA_W-1:0] data;
  } operand_t;

  typedef enum logic [1:0] {
    ENT_HOLD,
    ENT_DISP,
    ENT_SHIFT,
    ENT_CLEAR
  } entry_op_e;

  function automatic logic [DATA_W-1:0] tag_mask(input int unsigned tag_width);
    return DATA_W'((64'd1 << tag_width) - 64'd1);
  endfunction

  // A pending operand whose tag matches the broadcast takes the broadcast value.
  function automatic operand_t wake_operand(input operand_t          op,
                                            input logic              en,
                                            input logic [DATA_W-1:0] mask,
                                            input logic [DATA_W-1:0] tag_ext,
                                            input logic [DATA_W-1:0] value);
    operand_t r;
    r = op;
    if (en && op.is_ref && ((op.data & mask) == tag_ext)) begin
      r.is_ref = 1'b0;
      r.data   = value;
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: dispatch, CDB and issue buses of the issue scheduler.
//   master : ID stage / CDB / FU side (drives flush, disp_*, cdb_*, issue_ready)
//   slave  : the scheduler (drives disp_ready, issue_valid, issue_*, entry_count)
interface issue_scheduler_if
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned ENTRY_NUM     = SCHED_ENTRY_NUM,
  parameter int unsigned TAG_WIDTH     = SCHED_TAG_WIDTH,
  parameter int unsigned PAYLOAD_WIDTH = SCHED_PAYLOAD_WIDTH
);
  localparam int unsigned CNT_W = $clog2(ENTRY_NUM + 1);

  logic                     flush;
  logic                     disp_valid;
  logic                     disp_ready;
  logic [PAYLOAD_WIDTH-1:0] disp_payload;
  logic                     disp_is_ref_1;
  logic                     disp_is_ref_2;
  logic [DATA_W-1:0]        disp_data_1;
  logic [DATA_W-1:0]        disp_data_2;
  logic                     cdb_valid;
  logic [TAG_WIDTH-1:0]     cdb_tag;
  logic [DATA_W-1:0]        cdb_data;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [PAYLOAD_WIDTH-1:0] issue_payload;
  logic [DATA_W-1:0]        issue_data_1;
  logic [DATA_W-1:0]        issue_data_2;
  logic [CNT_W-1:0]         entry_count;

  modport master (
    output flush, disp_valid, disp_payload, disp_is_ref_1, disp_is_ref_2,
           disp_data_1, disp_data_2, cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  disp_ready, issue_valid, issue_payload, issue_data_1, issue_data_2,
           entry_count
  );

  modport slave (
    input  flush, disp_valid, disp_payload, disp_is_ref_1, disp_is_ref_2,
           disp_data_1, disp_data_2, cdb_valid, cdb_tag, cdb_data, issue_ready,
    output disp_ready, issue_valid, issue_payload, issue_data_1, issue_data_2,
           entry_count
  );

endinterface

// File: rtl/issue_scheduler_entry.sv
// sched_entry: one reservation-station slot {valid, payload, 2x operand}.
//   clk, rst (sync, active-low)
//   op                 : hold (with wakeup) / load from dispatch / load from upper neighbour / clear
//   cdb_*              : result broadcast, snooped for wakeup and for dispatch capture
//   disp_*             : raw dispatch operands
//   up_*               : upper neighbour's state, already woken, used when compacting
//   valid, payload     : stored state
//   woke_opnd_1/2      : stored operands with this cycle's broadcast applied
//   iss_opnd_1/2, ready: operands and readiness seen by the issue select
// Macro ISSUE_SCHED_FAST_WAKEUP_EN: readiness and issue operands include the current broadcast.
module sched_entry
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned TAG_WIDTH     = SCHED_TAG_WIDTH,
  parameter int unsigned PAYLOAD_WIDTH = SCHED_PAYLOAD_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  entry_op_e                op,
  input  logic                     cdb_valid,
  input  logic [TAG_WIDTH-1:0]     cdb_tag,
  input  logic [DATA_W-1:0]        cdb_data,
  input  logic [PAYLOAD_WIDTH-1:0] disp_payload,
  input  operand_t                 disp_opnd_1,
  input  operand_t                 disp_opnd_2,
  input  logic                     up_valid,
  input  logic [PAYLOAD_WIDTH-1:0] up_payload,
  input  operand_t                 up_opnd_1,
  input  operand_t                 up_opnd_2,
  output logic                     valid,
  output logic [PAYLOAD_WIDTH-1:0] payload,
  output operand_t                 woke_opnd_1,
  output operand_t                 woke_opnd_2,
  output operand_t                 iss_opnd_1,
  output operand_t                 iss_opnd_2,
  output logic                     ready
);
  localparam logic [DATA_W-1:0] TAG_MASK = tag_mask(TAG_WIDTH);

  logic                     valid_q, valid_d;
  logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
  operand_t                 opnd_1_q, opnd_1_d, opnd_2_q, opnd_2_d;
  logic [DATA_W-1:0]        tag_ext;

  assign tag_ext     = DATA_W'(cdb_tag);
  assign woke_opnd_1 = wake_operand(opnd_1_q, cdb_valid & valid_q, TAG_MASK, tag_ext, cdb_data);
  assign woke_opnd_2 = wake_operand(opnd_2_q, cdb_valid & valid_q, TAG_MASK, tag_ext, cdb_data);

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    opnd_1_d  = woke_opnd_1;
    opnd_2_d  = woke_opnd_2;
    unique case (op)
      ENT_HOLD: ;
      ENT_DISP: begin
        valid_d   = 1'b1;
        payload_d = disp_payload;
        opnd_1_d  = wake_operand(disp_opnd_1, cdb_valid, TAG_MASK, tag_ext, cdb_data);
        opnd_2_d  = wake_operand(disp_opnd_2, cdb_valid, TAG_MASK, tag_ext, cdb_data);
      end
      ENT_SHIFT: begin
        valid_d   = up_valid;
        payload_d = up_payload;
        opnd_1_d  = up_opnd_1;
        opnd_2_d  = up_opnd_2;
      end
      default: begin
        valid_d   = 1'b0;
        payload_d = '0;
        opnd_1_d  = '0;
        opnd_2_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      opnd_1_q  <= '0;
      opnd_2_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      opnd_1_q  <= opnd_1_d;
      opnd_2_q  <= opnd_2_d;
    end
  end

  assign valid   = valid_q;
  assign payload = payload_q;

`ifdef ISSUE_SCHED_FAST_WAKEUP_EN
  assign iss_opnd_1 = woke_opnd_1;
  assign iss_opnd_2 = woke_opnd_2;
  assign ready      = valid_q & ~woke_opnd_1.is_ref & ~woke_opnd_2.is_ref;
`else
  assign iss_opnd_1 = opnd_1_q;
  assign iss_opnd_2 = opnd_2_q;
  assign ready      = valid_q & ~opnd_1_q.is_ref & ~opnd_2_q.is_ref;
`endif

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: age-ordered reservation station feeding one execution unit.
//   clk, rst (sync, active-low)
//   bus (issue_scheduler_if.slave): flush, dispatch (disp_*), result broadcast (cdb_*),
//     issue handshake (issue_*), entry_count
// Slot 0 holds the oldest op; valid slots are contiguous from 0. The lowest ready slot
// issues; slots above it shift down one on issue.
// Macro ISSUE_SCHED_FAST_WAKEUP_EN: a broadcast can make an op issuable in the same cycle.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned ENTRY_NUM     = SCHED_ENTRY_NUM,
  parameter int unsigned TAG_WIDTH     = SCHED_TAG_WIDTH,
  parameter int unsigned PAYLOAD_WIDTH = SCHED_PAYLOAD_WIDTH
) (
  input logic              clk,
  input logic              rst,
  issue_scheduler_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(ENTRY_NUM + 1);
  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);

  logic [CNT_W-1:0]         count_q, count_d, disp_idx;
  logic [IDX_W-1:0]         sel_idx;
  logic                     sel_found, disp_fire, issue_fire, disp_ready;
  operand_t                 disp_opnd_1, disp_opnd_2;

  entry_op_e                ent_op      [ENTRY_NUM];
  logic                     ent_valid   [ENTRY_NUM];
  logic [PAYLOAD_WIDTH-1:0] ent_payload [ENTRY_NUM];
  operand_t                 ent_woke_1  [ENTRY_NUM];
  operand_t                 ent_woke_2  [ENTRY_NUM];
  operand_t                 ent_iss_1   [ENTRY_NUM];
  operand_t                 ent_iss_2   [ENTRY_NUM];
  logic                     ent_ready   [ENTRY_NUM];
  logic                     up_valid    [ENTRY_NUM];
  logic [PAYLOAD_WIDTH-1:0] up_payload  [ENTRY_NUM];
  operand_t                 up_opnd_1   [ENTRY_NUM];
  operand_t                 up_opnd_2   [ENTRY_NUM];

  assign disp_opnd_1 = '{is_ref: bus.disp_is_ref_1, data: bus.disp_data_1};
  assign disp_opnd_2 = '{is_ref: bus.disp_is_ref_2, data: bus.disp_data_2};

  // No issue credit: a full station stays closed even if an issue fires this cycle.
  assign disp_ready = (count_q != CNT_W'(ENTRY_NUM));
  assign disp_fire  = bus.disp_valid & disp_ready;
  assign issue_fire = sel_found & bus.issue_ready;
  // The new op lands just above the survivors, so one slot lower when an issue compacts.
  assign disp_idx   = count_q - CNT_W'(issue_fire);

  for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_entry
    if (g == ENTRY_NUM - 1) begin : g_last
      assign up_valid[g]   = 1'b0;
      assign up_payload[g] = '0;
      assign up_opnd_1[g]  = '0;
      assign up_opnd_2[g]  = '0;
    end else begin : g_inner
      assign up_valid[g]   = ent_valid[g+1];
      assign up_payload[g] = ent_payload[g+1];
      assign up_opnd_1[g]  = ent_woke_1[g+1];
      assign up_opnd_2[g]  = ent_woke_2[g+1];
    end

    sched_entry #(
      .TAG_WIDTH     (TAG_WIDTH),
      .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
    ) u_entry (
      .clk          (clk),
      .rst          (rst),
      .op           (ent_op[g]),
      .cdb_valid    (bus.cdb_valid),
      .cdb_tag      (bus.cdb_tag),
      .cdb_data     (bus.cdb_data),
      .disp_payload (bus.disp_payload),
      .disp_opnd_1  (disp_opnd_1),
      .disp_opnd_2  (disp_opnd_2),
      .up_valid     (up_valid[g]),
      .up_payload   (up_payload[g]),
      .up_opnd_1    (up_opnd_1[g]),
      .up_opnd_2    (up_opnd_2[g]),
      .valid        (ent_valid[g]),
      .payload      (ent_payload[g]),
      .woke_opnd_1  (ent_woke_1[g]),
      .woke_opnd_2  (ent_woke_2[g]),
      .iss_opnd_1   (ent_iss_1[g]),
      .iss_opnd_2   (ent_iss_2[g]),
      .ready        (ent_ready[g])
    );
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      if (!sel_found && ent_ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      ent_op[i] = ENT_HOLD;
      if (bus.flush)                                  ent_op[i] = ENT_CLEAR;
      else if (disp_fire && CNT_W'(i) == disp_idx)    ent_op[i] = ENT_DISP;
      else if (issue_fire && IDX_W'(i) >= sel_idx)    ent_op[i] = ENT_SHIFT;
    end
  end

  always_comb begin
    count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
    if (bus.flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  always_comb begin
    bus.issue_payload = '0;
    bus.issue_data_1  = '0;
    bus.issue_data_2  = '0;
    if (sel_found) begin
      bus.issue_payload = ent_payload[sel_idx];
      bus.issue_data_1  = ent_iss_1[sel_idx].data;
      bus.issue_data_2  = ent_iss_2[sel_idx].data;
    end
  end

  assign bus.issue_valid = sel_found;
  assign bus.disp_ready  = disp_ready;
  assign bus.entry_count = count_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed scenarios plus randomized traffic for issue_scheduler,
// checked every cycle against a queue-based model of the station.
module tb_issue_scheduler;
  localparam int N  = 4;
  localparam int TW = 6;
  localparam int PW = 16;
`ifdef ISSUE_SCHED_FAST_WAKEUP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_scheduler_if #(.ENTRY_NUM(N), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) bus ();

  issue_scheduler #(.ENTRY_NUM(N), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [PW-1:0] pl;
    bit            r1;
    logic [31:0]   d1;
    bit            r2;
    logic [31:0]   d2;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input bit r, input logic [31:0] d);
    logic [TW-1:0] t;
    t = d[TW-1:0];
    return r && bus.cdb_valid && (t == bus.cdb_tag);
  endfunction

  task automatic idle();
    bus.flush         = 1'b0;
    bus.disp_valid    = 1'b0;
    bus.disp_payload  = '0;
    bus.disp_is_ref_1 = 1'b0;
    bus.disp_is_ref_2 = 1'b0;
    bus.disp_data_1   = '0;
    bus.disp_data_2   = '0;
    bus.cdb_valid     = 1'b0;
    bus.cdb_tag       = '0;
    bus.cdb_data      = '0;
    bus.issue_ready   = 1'b0;
  endtask

  task automatic disp(input logic [PW-1:0] pl, input bit r1, input logic [31:0] d1,
                      input bit r2, input logic [31:0] d2);
    bus.disp_valid    = 1'b1;
    bus.disp_payload  = pl;
    bus.disp_is_ref_1 = r1;
    bus.disp_data_1   = d1;
    bus.disp_is_ref_2 = r2;
    bus.disp_data_2   = d2;
  endtask

  task automatic cdb(input logic [TW-1:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_data  = data;
  endtask

  // Check outputs mid-cycle against the model, then advance the model across the edge.
  task automatic step();
    int            sel;
    logic [PW-1:0] e_pl;
    logic [31:0]   e1, e2;
    bit            fire, dfire;
    @(negedge clk);
    sel = -1; e_pl = '0; e1 = '0; e2 = '0;
    for (int i = 0; i < q.size() && sel < 0; i++) begin
      bit          ok1, ok2;
      logic [31:0] v1, v2;
      ok1 = !q[i].r1; v1 = q[i].d1;
      ok2 = !q[i].r2; v2 = q[i].d2;
      if (FAST && hit(q[i].r1, q[i].d1)) begin ok1 = 1'b1; v1 = bus.cdb_data; end
      if (FAST && hit(q[i].r2, q[i].d2)) begin ok2 = 1'b1; v2 = bus.cdb_data; end
      if (ok1 && ok2) begin sel = i; e_pl = q[i].pl; e1 = v1; e2 = v2; end
    end
    chk("disp_ready",    32'(bus.disp_ready),    32'(q.size() != N));
    chk("entry_count",   32'(bus.entry_count),   32'(q.size()));
    chk("issue_valid",   32'(bus.issue_valid),   32'(sel >= 0));
    chk("issue_payload", 32'(bus.issue_payload), 32'(e_pl));
    chk("issue_data_1",  bus.issue_data_1,       e1);
    chk("issue_data_2",  bus.issue_data_2,       e2);
    fire  = (sel >= 0) && bus.issue_ready;
    dfire = bus.disp_valid && (q.size() != N);
    @(posedge clk);
    if (!rst || bus.flush) begin
      q.delete();
    end else begin
      if (fire) q.delete(sel);
      foreach (q[i]) begin
        if (hit(q[i].r1, q[i].d1)) begin q[i].r1 = 1'b0; q[i].d1 = bus.cdb_data; end
        if (hit(q[i].r2, q[i].d2)) begin q[i].r2 = 1'b0; q[i].d2 = bus.cdb_data; end
      end
      if (dfire) begin
        ent_t e;
        e.pl = bus.disp_payload;
        e.r1 = bus.disp_is_ref_1; e.d1 = bus.disp_data_1;
        e.r2 = bus.disp_is_ref_2; e.d2 = bus.disp_data_2;
        if (hit(e.r1, e.d1)) begin e.r1 = 1'b0; e.d1 = bus.cdb_data; end
        if (hit(e.r2, e.d2)) begin e.r2 = 1'b0; e.d2 = bus.cdb_data; end
        q.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    rst = 1'b1;
    chk("rst_issue_valid", 32'(bus.issue_valid),   32'd0);
    chk("rst_count",       32'(bus.entry_count),   32'd0);
    chk("rst_disp_ready",  32'(bus.disp_ready),    32'd1);
    chk("rst_payload",     32'(bus.issue_payload), 32'd0);

    // Value op into empty station: issuable next cycle.
    disp(16'h0001, 1'b0, 32'd5, 1'b0, 32'd7);
    step();
    idle();
    chk("t1_valid", 32'(bus.issue_valid),  32'd1);
    chk("t1_d1",    bus.issue_data_1,      32'd5);
    chk("t1_d2",    bus.issue_data_2,      32'd7);
    chk("t1_count", 32'(bus.entry_count),  32'd1);
    bus.issue_ready = 1'b1;
    step();
    chk("t1_count0", 32'(bus.entry_count), 32'd0);

    // Fill with ops waiting on tag 3 (upper data bits must not affect the match).
    for (int i = 0; i < N; i++) begin
      disp(16'(16'hA0 + i), 1'b1, 32'h5A00_0003, 1'b1, 32'h0000_0003);
      step();
    end
    chk("t2_full", 32'(bus.disp_ready), 32'd0);
    disp(16'hBEEF, 1'b0, 32'd1, 1'b0, 32'd2);
    step();
    chk("t2_count_held", 32'(bus.entry_count), 32'(N));
    idle();
    cdb(6'd3, 32'h0000_00AB);
    step();
    idle();
    bus.issue_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("t2_order", 32'(bus.issue_payload), 32'(16'hA0 + i));
      chk("t2_d1",    bus.issue_data_1,       32'h0000_00AB);
      chk("t2_d2",    bus.issue_data_2,       32'h0000_00AB);
      step();
    end
    chk("t2_empty", 32'(bus.entry_count), 32'd0);

    // Dispatch-time snoop.
    idle();
    disp(16'h000C, 1'b1, 32'd9, 1'b0, 32'h22);
    cdb(6'd9, 32'h11);
    step();
    idle();
    chk("t3_valid", 32'(bus.issue_valid), 32'd1);
    chk("t3_d1",    bus.issue_data_1,     32'h11);
    chk("t3_d2",    bus.issue_data_2,     32'h22);
    bus.issue_ready = 1'b1;
    step();

    // Younger ready op bypasses an older waiting one.
    idle();
    disp(16'h0040, 1'b1, 32'd2, 1'b0, 32'd1);
    step();
    disp(16'h0041, 1'b0, 32'd3, 1'b0, 32'd4);
    step();
    idle();
    bus.issue_ready = 1'b1;
    chk("t4_bypass", 32'(bus.issue_payload), 32'h41);
    step();
    cdb(6'd2, 32'h77);
    step();
    idle();
    bus.issue_ready = 1'b1;
    step();
    chk("t4_empty", 32'(bus.entry_count), 32'd0);

    // Flush overrides a simultaneous dispatch; reset clears mid-stream.
    idle();
    for (int i = 0; i < 3; i++) begin
      disp(16'(16'h50 + i), 1'b1, 32'd7, 1'b0, 32'd0);
      step();
    end
    disp(16'h0060, 1'b0, 32'd1, 1'b0, 32'd2);
    bus.flush = 1'b1;
    step();
    idle();
    chk("t5_flush_count", 32'(bus.entry_count), 32'd0);
    chk("t5_flush_valid", 32'(bus.issue_valid), 32'd0);
    disp(16'h0070, 1'b0, 32'd8, 1'b0, 32'd9);
    step();
    step();
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5_rst_count", 32'(bus.entry_count),   32'd0);
    chk("t5_rst_pl",    32'(bus.issue_payload), 32'd0);
    chk("t5_rst_d1",    bus.issue_data_1,       32'd0);

    // Randomized traffic; small tag range keeps wakeups frequent.
    for (int c = 0; c < 1500; c++) begin
      bit r1, r2;
      r1 = ($urandom_range(0, 1) == 1);
      r2 = ($urandom_range(0, 1) == 1);
      idle();
      if ($urandom_range(0, 2) != 0)
        disp(16'($urandom),
             r1, r1 ? {$urandom_range(0, 255), 24'd0} | 32'($urandom_range(0, 7)) : $urandom,
             r2, r2 ? {$urandom_range(0, 255), 24'd0} | 32'($urandom_range(0, 7)) : $urandom);
      if ($urandom_range(0, 1) == 1) cdb(6'($urandom_range(0, 7)), $urandom);
      bus.issue_ready = ($urandom_range(0, 9) < 7);
      bus.flush       = ($urandom_range(0, 59) == 0);
      rst             = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
